// File: rtl/add_pkg.sv
// Shared types for the handshaked add/accumulate pipeline.
package add_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_ACC  = 2'b01,
        MODE_LOAD = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/add_skid_fifo.sv
// Two-entry registered output buffer; the head entry drives out_data directly from a flop.
module add_skid_fifo
    import add_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    // Handshake: a beat transfers on the rising edge where valid && ready are both high;
    // in_ready and out_valid are flops, so neither depends combinationally on the other side.
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          push;
    logic          pop;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = head;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            head      <= '0;
            tail      <= '0;
        end else begin
            count     <= count_next;
            in_ready  <= (32'(count_next) < FIFO_DEPTH);
            out_valid <= (count_next != 2'd0);
            case (count)
                2'd0: begin
                    if (push) head <= in_data;
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_data;
                    end else if (push) begin
                        tail <= in_data;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen here.
                    if (pop) head <= tail;
                end
            endcase
        end
    end

endmodule

// File: rtl/add_accum_pipe.sv
// Handshaked adder/accumulator: results are computed at accept time and queued in a 2-entry buffer.
module add_accum_pipe
    import add_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int ACC_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic [ACC_W-1:0] acc_value
);

    if (ACC_W < WIDTH + 1) begin : g_bad_width
        $error("add_accum_pipe: ACC_W must be at least WIDTH+1");
    end

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } result_t;

    mode_e            mode;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] ab;
    logic [ACC_W:0]   t;
    result_t          res;
    result_t          head;
    logic             accept;

    assign mode   = mode_e'(in_mode);
    assign accept = in_valid && in_ready;

    always_comb begin
        // a+b always fits in ACC_W because ACC_W >= WIDTH+1.
        ab       = ACC_W'(in_a) + ACC_W'(in_b);
        t        = {1'b0, acc} + {1'b0, ab};
        res.sum  = ab;
        res.ovf  = 1'b0;
        acc_next = acc;
        case (mode)
            MODE_ACC: begin
                res.sum = t[ACC_W-1:0];
                if (t[ACC_W]) begin
                    res.ovf = 1'b1;
                    if (SATURATE) res.sum = '1;
                end
                acc_next = res.sum;
            end
            MODE_LOAD: begin
                acc_next = ab;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_next;
        end
    end

    assign acc_value = acc;

    add_skid_fifo #(
        .DW($bits(result_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (res),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head)
    );

    assign out_sum = head.sum;
    assign out_ovf = head.ovf;

endmodule

// File: tb/tb_add_accum_pipe.sv
// Directed table-driven bench for add_accum_pipe (wrapping instance plus a saturating twin).
module tb_add_accum_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_mode;
    logic       out_ready;

    logic       in_ready,  out_valid,  out_ovf;
    logic [7:0] out_sum,   acc_value;
    logic       s_in_ready, s_out_valid, s_out_ovf;
    logic [7:0] s_out_sum,  s_acc_value;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];

    typedef struct {
        logic [1:0] mode;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] sum;
        logic       ovf;
        logic [7:0] acc;
    } vec_t;

    vec_t vecs[14];

    add_accum_pipe #(.WIDTH(4), .ACC_W(8), .SATURATE(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .acc_value(acc_value)
    );

    add_accum_pipe #(.WIDTH(4), .ACC_W(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sum(s_out_sum), .out_ovf(s_out_ovf), .acc_value(s_acc_value)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: every pop is compared against the oldest expected result.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_sum), 32'hffff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(out_sum), 32'(e[8:1]));
                check("sb_ovf", 32'(out_ovf), 32'(e[0]));
            end
        end
    end

    // Driver: call at a negedge; returns at the negedge after the accept edge.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_mode  = v.mode;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back({v.sum, v.ovf});
            @(negedge clk);
            in_valid = 1'b0;
            check("acc_value", 32'(acc_value), 32'(v.acc));
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t v;
        // Test 1: ADD
        vecs[0]  = '{2'b00, 4'd4,  4'd4,  8'd8,   1'b0, 8'd0};
        vecs[1]  = '{2'b00, 4'd15, 4'd11, 8'd26,  1'b0, 8'd0};
        // Test 2: LOAD then nine ACC 15+15
        vecs[2]  = '{2'b10, 4'd5,  4'd6,  8'd11,  1'b0, 8'd11};
        vecs[3]  = '{2'b01, 4'd15, 4'd15, 8'd41,  1'b0, 8'd41};
        vecs[4]  = '{2'b01, 4'd15, 4'd15, 8'd71,  1'b0, 8'd71};
        vecs[5]  = '{2'b01, 4'd15, 4'd15, 8'd101, 1'b0, 8'd101};
        vecs[6]  = '{2'b01, 4'd15, 4'd15, 8'd131, 1'b0, 8'd131};
        vecs[7]  = '{2'b01, 4'd15, 4'd15, 8'd161, 1'b0, 8'd161};
        vecs[8]  = '{2'b01, 4'd15, 4'd15, 8'd191, 1'b0, 8'd191};
        vecs[9]  = '{2'b01, 4'd15, 4'd15, 8'd221, 1'b0, 8'd221};
        vecs[10] = '{2'b01, 4'd15, 4'd15, 8'd251, 1'b0, 8'd251};
        vecs[11] = '{2'b01, 4'd15, 4'd15, 8'd25,  1'b1, 8'd25};
        // Test 6: reserved mode with acc=30
        vecs[12] = '{2'b10, 4'd15, 4'd15, 8'd30,  1'b0, 8'd30};
        vecs[13] = '{2'b11, 4'd7,  4'd8,  8'd15,  1'b0, 8'd30};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_acc",       32'(acc_value), 32'd0);
        rst_n = 1'b1;

        // Empty buffer with out_ready high: nothing should appear.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_underflow", 32'(out_valid), 32'd0);
        check("idle_in_ready",     32'(in_ready),  32'd1);

        // First beat: out_valid must be up one cycle after accept.
        send(vecs[0]);
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_latency_sum",   32'(out_sum),   32'd8);
        for (int i = 1; i < 14; i++) begin
            send(vecs[i]);
            if (i == 11) begin
                check("t2_sat_sum", 32'(s_out_sum),   32'd255);
                check("t2_sat_ovf", 32'(s_out_ovf),   32'd1);
                check("t2_sat_acc", 32'(s_acc_value), 32'd255);
            end
        end
        drain();

        // Test 3: backpressure
        out_ready = 1'b0;
        v = '{2'b00, 4'd1, 4'd1, 8'd2, 1'b0, 8'd30};
        send(v);
        check("t3_ready_after_1", 32'(in_ready), 32'd1);
        v = '{2'b00, 4'd2, 4'd2, 8'd4, 1'b0, 8'd30};
        send(v);
        check("t3_ready_after_2", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3; in_mode = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("t3_held_ready", 32'(in_ready),  32'd0);
            check("t3_stable_sum", 32'(out_sum),   32'd2);
            check("t3_stable_vld", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        v = '{2'b00, 4'd3, 4'd3, 8'd6, 1'b0, 8'd30};
        send(v);
        drain();

        // Test 4: full throughput
        for (int i = 0; i < 16; i++) begin
            v.mode = 2'b00;
            v.a    = 4'(i);
            v.b    = 4'((i * 3) % 16);
            v.sum  = 8'(i + (i * 3) % 16);
            v.ovf  = 1'b0;
            v.acc  = 8'd30;
            send(v);
            check("t4_in_ready", 32'(in_ready), 32'd1);
        end
        drain();

        // Test 5: reset mid-operation with two buffered results and acc=41
        out_ready = 1'b0;
        v = '{2'b10, 4'd15, 4'd15, 8'd30, 1'b0, 8'd30};
        send(v);
        v = '{2'b01, 4'd5, 4'd6, 8'd41, 1'b0, 8'd41};
        send(v);
        check("t5_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_acc",       32'(acc_value), 32'd0);
        check("t5_rst_in_ready",  32'(in_ready),  32'd1);
        check("t5_rst_out_sum",   32'(out_sum),   32'd0);
        exp_q.delete();
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; in_mode = 2'b10;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_no_accept_in_rst", 32'(out_valid), 32'd0);
        check("t5_acc_after_rst",    32'(acc_value), 32'd0);
        out_ready = 1'b1;
        v = '{2'b00, 4'd1, 4'd2, 8'd3, 1'b0, 8'd0};
        send(v);
        check("t5_post_sum", 32'(out_sum), 32'd3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
